stat_core_sequencer: RTL and testbench
======================================

// Module: stat_core_sequencer
// PURPOSE
// - Shares one combinational Stat benchmark core (32-bit input vector, 32-bit output vector, no clock)
//   among NUM_REQ requesters. Arbitration is round-robin.
// - Per transaction: registers the granted vector onto the core inputs, waits SETTLE_CYC cycles,
//   captures the core outputs and returns them with the requester ID over a valid/ready response port.
// - Sits between the test/lock-evaluation harness masters and the benchmark core instance.
// PARAMETERS
// - NUM_REQ     4   number of requesters (2..8)
// - IN_W        32  core input width
// - OUT_W       32  core output width
// - SETTLE_CYC  2   cycles core_in is held before capture (>=1)
// - ID_W        $clog2(NUM_REQ)  requester ID width (derived, not overridden)
// PORTS
// - clk        in   1              single clock, rising edge
// - rst_n      in   1              synchronous active-low reset
// - req_valid  in   NUM_REQ        per-requester request valid
// - req_ready  out  NUM_REQ        per-requester accept; one-hot or zero
// - req_vec    in   NUM_REQ*IN_W   request vectors; requester i at [i*IN_W +: IN_W]
// - core_in    out  IN_W           registered drive to core inputs
// - core_out   in   OUT_W          core outputs (combinational from core_in)
// - rsp_valid  out  1              response valid
// - rsp_ready  in   1              response accept
// - rsp_data   out  OUT_W          captured core_out
// - rsp_id     out  ID_W           requester index of this response
// - busy       out  1              state != IDLE
// - done_cnt   out  16             completed responses; wraps at 2^16
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): state=IDLE, core_in=0, rsp_valid=0, rsp_data=0, rsp_id=0,
//   rr_ptr=0, done_cnt=0.
// - Reset mid-transaction aborts the transaction. No response is produced for it.
// - FSM states: IDLE -> SETTLE -> RESP -> IDLE.
// - IDLE:
//   - Arbiter picks the first asserted req_valid scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   - req_ready[g] = 1 combinationally for that winner only. req_ready = 0 in all other states.
//   - On req_valid[g] & req_ready[g] at edge T:
//     - core_in <= req_vec[g], rsp_id <= g
//     - cnt <= SETTLE_CYC-1
//     - rr_ptr <= (g+1) mod NUM_REQ
//     - state <= SETTLE
//   - No request: stay in IDLE; rr_ptr and core_in are unchanged.
// - SETTLE:
//   - If cnt != 0: cnt decrements.
//   - If cnt == 0: rsp_data <= core_out, rsp_valid <= 1, state <= RESP.
//   - rsp_valid therefore rises SETTLE_CYC+1 edges after the accept edge T.
// - RESP:
//   - rsp_data and rsp_id are held stable while rsp_valid=1 && !rsp_ready.
//   - On rsp_valid & rsp_ready: rsp_valid <= 0, done_cnt <= done_cnt+1 (wrapping), state <= IDLE.
//   - The next accept can happen no earlier than the cycle after the response handshake.
//   - Minimum period per transaction is SETTLE_CYC+2 cycles.
// - core_in changes only at an accept edge. It holds the last vector between transactions.
// - A requester may drop req_valid before it is granted without side effects.
//   req_vec is sampled only at the accept edge.
// - rr_ptr advances only on an accept, so an idle requester never loses its turn.
// - Fairness: with all req_valid held high, grants are 0,1,...,NUM_REQ-1,0,...
// STRUCTURE
// - Shared package stat_seq_pkg:
//   - state enum {IDLE, SETTLE, RESP}
//   - default widths, and the SETTLE counter width $clog2(SETTLE_CYC+1)
// - One sub-module stat_rr_arbiter (NUM_REQ):
//   - inputs: req, ptr
//   - outputs: one-hot gnt, gnt_idx, any
//   - purely combinational
// - The FSM, datapath registers and counters live in the top module.
// TESTING
// - Reset: rst_n=0 for 2 cycles with req_valid=4'hF ->
//   req_ready=0, rsp_valid=0, core_in=0, done_cnt=0, busy=0.
// - Single request, SETTLE_CYC=2: req_valid=4'b0100, vec2=32'hA5A5_0F0F accepted at T ->
//   core_in=32'hA5A5_0F0F from T+1; rsp_valid=1 at T+3;
//   rsp_data = model(32'hA5A5_0F0F); rsp_id=2.
// - Round-robin: req_valid=4'hF held, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0;
//   done_cnt=5; accepts exactly 4 cycles apart.
// - Backpressure: rsp_ready=0 for 10 cycles after rsp_valid ->
//   rsp_data/rsp_id stable, req_ready=0, core_in unchanged; next grant after rsp_ready=1.
// - Reset mid-op: rst_n=0 in the SETTLE cycle ->
//   no rsp_valid afterwards, rr_ptr=0, first post-reset grant goes to the lowest asserted requester.
// - Wrap: preload 16'hFFFF completions by running 65535 transactions,
//   or force done_cnt in simulation -> next completion gives done_cnt=0.

Source files
------------

// File: rtl/stat_seq_pkg.sv
// Shared state encoding, default widths and counter sizing for the Stat core sequencer.
package stat_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_IN_W       = 32;
  localparam int DEF_OUT_W      = 32;
  localparam int DEF_SETTLE_CYC = 2;
  localparam int DEF_CNT_W      = $clog2(DEF_SETTLE_CYC + 1);

  // Settle counter width; kept at least one bit for the shortest settle time.
  function automatic int cnt_width(input int settle_cyc);
    return (settle_cyc < 1) ? 1 : $clog2(settle_cyc + 1);
  endfunction

endpackage

// File: rtl/stat_core_sequencer_if.sv
// Request/response bus between the harness masters and the Stat core sequencer.
interface stat_core_sequencer_if
  import stat_seq_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*IN_W-1:0] req_vec;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [OUT_W-1:0]        rsp_data;
  logic [ID_W-1:0]         rsp_id;

  modport master (
    output req_valid, req_vec, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_vec, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/stat_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after i_ptr wins.
module stat_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_gnt_idx,
  output logic               o_any
);

  always_comb begin
    int w_idx;
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    w_idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = (int'(i_ptr) + i) % NUM_REQ;
      if (!o_any && i_req[w_idx]) begin
        o_any        = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_gnt_idx    = ID_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/stat_core_sequencer.sv
// Time-shares one combinational Stat core among NUM_REQ requesters, one transaction at a time.
//   state  | meaning
//   IDLE   | arbitrating; grant offered to the round-robin winner
//   SETTLE | core_in held, counting down until core_out is stable
//   RESP   | captured result presented until rsp_ready
module stat_core_sequencer
  import stat_seq_pkg::*;
#(
  parameter  int NUM_REQ    = DEF_NUM_REQ,
  parameter  int IN_W       = DEF_IN_W,
  parameter  int OUT_W      = DEF_OUT_W,
  parameter  int SETTLE_CYC = DEF_SETTLE_CYC,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stat_core_sequencer_if.slave bus,
  output logic [IN_W-1:0]      core_in,
  input  logic [OUT_W-1:0]     core_out,
  output logic                 busy,
  output logic [15:0]          done_cnt
);

  localparam int CNT_W = cnt_width(SETTLE_CYC);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [IN_W-1:0]    r_core_in;
  logic               r_rsp_valid;
  logic [OUT_W-1:0]   r_rsp_data;
  logic [ID_W-1:0]    r_rsp_id;
  logic [15:0]        r_done_cnt;

  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_gnt_idx;
  logic               w_any;
  logic               w_accept;
  logic [ID_W-1:0]    w_next_ptr;

  stat_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req     (bus.req_valid),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  // No grant is advertised while reset is held, so nothing looks accepted during reset.
  assign w_accept      = rst_n && (r_state == IDLE) && w_any;
  assign bus.req_ready = w_accept ? w_gnt : '0;
  assign w_next_ptr    = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rr_ptr    <= '0;
      r_core_in   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_done_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_core_in <= bus.req_vec[int'(w_gnt_idx)*IN_W +: IN_W];
            r_rsp_id  <= w_gnt_idx;
            r_cnt     <= CNT_W'(SETTLE_CYC - 1);
            r_rr_ptr  <= w_next_ptr;
            r_state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_rsp_data  <= core_out;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_done_cnt  <= r_done_cnt + 16'd1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign core_in       = r_core_in;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_id    = r_rsp_id;
  assign busy          = (r_state != IDLE);
  assign done_cnt      = r_done_cnt;

endmodule

// File: tb/tb_stat_core_sequencer.sv
// Randomized scoreboard bench for stat_core_sequencer with a transaction-level reference model.
module tb_stat_core_sequencer;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SC = 2;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] core_in;
  logic [31:0] core_out;
  logic        busy;
  logic [15:0] done_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t        exp_q[$];
  logic [1:0]  id_log[$];

  // Transaction-level model state
  bit          m_idle;
  int          m_ptr;
  int          m_rsp_at;
  logic [31:0] m_core_in;
  logic [15:0] m_done;
  int          cyc;

  bit          use_fix;
  logic [31:0] fix_vec;

  stat_core_sequencer_if #(.NUM_REQ(N), .IN_W(W), .OUT_W(W)) bus ();

  stat_core_sequencer #(.NUM_REQ(N), .IN_W(W), .OUT_W(W), .SETTLE_CYC(SC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .core_in  (core_in),
    .core_out (core_out),
    .busy     (busy),
    .done_cnt (done_cnt)
  );

  // Stand-in for the benchmark core: any fixed combinational mixing function.
  function automatic logic [31:0] core_model(input logic [31:0] x);
    return (x ^ {x[15:0], x[31:16]}) + 32'h1357_9BDF;
  endfunction

  assign core_out = core_model(core_in);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic model_reset();
    m_idle    = 1'b1;
    m_ptr     = 0;
    m_rsp_at  = 0;
    m_core_in = '0;
    m_done    = '0;
    exp_q.delete();
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance the model for the coming edge.
  task automatic step(input logic rstn, input logic [N-1:0] v, input logic rr);
    logic [31:0] vecs[N];
    logic [N-1:0] exp_ready;
    logic         exp_valid;
    int           g;
    exp_t         e;
    rst_n         = rstn;
    bus.req_valid = v;
    bus.rsp_ready = rr;
    for (int i = 0; i < N; i++) begin
      vecs[i] = use_fix ? fix_vec : $urandom();
      bus.req_vec[i*W +: W] = vecs[i];
    end
    @(negedge clk);
    g = -1;
    if (rstn && m_idle) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    exp_valid = !m_idle && (cyc >= m_rsp_at);
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
    chk("busy",      32'(busy),          32'(!m_idle));
    chk("core_in",   core_in,            m_core_in);
    chk("done_cnt",  32'(done_cnt),      32'(m_done));
    if (!rstn) begin
      model_reset();
    end else if (m_idle) begin
      if (g >= 0) begin
        e.id   = 2'(g);
        e.data = core_model(vecs[g]);
        exp_q.push_back(e);
        m_core_in = vecs[g];
        m_ptr     = (g + 1) % N;
        m_idle    = 1'b0;
        m_rsp_at  = cyc + SC + 1;
      end
    end else if (cyc >= m_rsp_at && rr) begin
      m_idle = 1'b1;
      m_done = m_done + 16'd1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every cycle rsp_valid is up, the head of the scoreboard must be on the bus.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.rsp_valid === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: got id=%0d data=%h, expected no response", bus.rsp_id, bus.rsp_data);
        end else begin
          if (bus.rsp_data !== exp_q[0].data || bus.rsp_id !== exp_q[0].id) begin
            n_fail++;
            $display("FAIL rsp_payload: got id=%0d data=%h, expected id=%0d data=%h",
                     bus.rsp_id, bus.rsp_data, exp_q[0].id, exp_q[0].data);
          end
          if (bus.rsp_ready === 1'b1) begin
            id_log.push_back(bus.rsp_id);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int rr_exp[5];
    rr_exp    = '{0, 1, 2, 3, 0};
    cyc       = 0;
    use_fix   = 1'b0;
    fix_vec   = '0;
    model_reset();
    rst_n         = 1'b0;
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b0;
    bus.req_vec   = '0;
    @(posedge clk);
    #1;
    cyc = 1;
    step(1'b0, 4'hF, 1'b0);

    // Single request from requester 2 with a known vector
    use_fix = 1'b1;
    fix_vec = 32'hA5A5_0F0F;
    step(1'b1, 4'b0100, 1'b1);
    use_fix = 1'b0;
    repeat (5) step(1'b1, 4'b0000, 1'b1);

    // Round-robin with everyone requesting, from a fresh reset
    step(1'b0, 4'hF, 1'b1);
    id_log.delete();
    repeat (20) step(1'b1, 4'hF, 1'b1);
    chk("rr_count", 32'(id_log.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < id_log.size()) chk("rr_order", 32'(id_log[i]), 32'(rr_exp[i]));
    end
    chk("rr_done_cnt", 32'(done_cnt), 32'd5);

    // Backpressure: response held for well over 10 cycles
    repeat (14) step(1'b1, 4'hF, 1'b0);
    repeat (4) step(1'b1, 4'hF, 1'b1);
    repeat (6) step(1'b1, 4'h0, 1'b1);

    // Reset during SETTLE: transaction is dropped and the pointer returns to 0
    step(1'b1, 4'b0010, 1'b1);
    step(1'b0, 4'b1001, 1'b1);
    step(1'b1, 4'b1001, 1'b1);
    repeat (5) step(1'b1, 4'b0000, 1'b1);

    // Random traffic
    repeat (400) step(1'b1, 4'($urandom()), ($urandom_range(3) != 0));
    repeat (6) step(1'b1, 4'b0000, 1'b1);

    // Completion counter wrap
    force dut.r_done_cnt = 16'hFFFF;
    m_done = 16'hFFFF;
    step(1'b1, 4'b0000, 1'b0);
    release dut.r_done_cnt;
    step(1'b1, 4'b0001, 1'b1);
    repeat (5) step(1'b1, 4'b0000, 1'b1);
    chk("wrap_done_cnt", 32'(done_cnt), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
